// File: rtl/plic_irq_cond_pkg.sv
// Shared PLIC constants: default interrupt conditioner dimensions.
package plic_irq_cond_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILT_W_DEF      = 4;

endpackage

// File: rtl/plic_irq_filter.sv
// Per-source glitch filter: commits a new level after L stable cycles, 1 cycle when off.
// No handshake; a rejected pulse sets a sticky flag that a concurrent clear cannot erase.
import plic_irq_cond_pkg::*;

module plic_irq_filter #(
  parameter int unsigned FILT_W = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample,
  input  logic              filt_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              glitch_clr,
  output logic              level,
  output logic              glitch
);

  logic              out_q;
  logic [FILT_W-1:0] cnt_q;
  logic              glitch_q;
  logic [FILT_W-1:0] lim;
  logic              glitch_set;

  // lim is L-1; a zero length degenerates to pass-through like a disabled filter.
  always_comb begin
    lim = '0;
    if (filt_en && (filt_len != '0)) begin
      lim = filt_len - 1'b1;
    end
  end

  assign glitch_set = (sample == out_q) && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= 1'b0;
      cnt_q    <= '0;
      glitch_q <= 1'b0;
    end else begin
      if (sample == out_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= lim) begin
        out_q <= sample;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      glitch_q <= glitch_set | (glitch_q & ~glitch_clr);
    end
  end

  assign level  = out_q;
  assign glitch = glitch_q;

endmodule

// File: rtl/plic_irq_cond.sv
// Interrupt conditioner ahead of the PLIC: sync chain, polarity, per-source filter.
// Latency SYNC_STAGES+max(L,1) cycles; no backpressure, outputs are registered levels.
import plic_irq_cond_pkg::*;

module plic_irq_cond #(
  parameter int unsigned N_SOURCE    = 30,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_W      = FILT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] irq_raw_i,
  input  logic [N_SOURCE-1:0] inv_i,
  input  logic [N_SOURCE-1:0] filt_en_i,
  input  logic [FILT_W-1:0]   filt_len_i,
  input  logic [N_SOURCE-1:0] glitch_clr_i,
  output logic [N_SOURCE-1:0] irq_sources_o,
  output logic [N_SOURCE-1:0] glitch_o
);

  // Kept as one vector chain so the whole synchronizer can be constrained as a group.
  logic [SYNC_STAGES-1:0][N_SOURCE-1:0] sync_q;
  logic [N_SOURCE-1:0]                  sample;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= irq_raw_i;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Polarity is applied after synchronization, so an inv_i change is filtered too.
  assign sample = sync_q[SYNC_STAGES-1] ^ inv_i;

  for (genvar i = 0; i < int'(N_SOURCE); i++) begin : g_src
    plic_irq_filter #(
      .FILT_W(FILT_W)
    ) u_filter (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .sample    (sample[i]),
      .filt_en   (filt_en_i[i]),
      .filt_len  (filt_len_i),
      .glitch_clr(glitch_clr_i[i]),
      .level     (irq_sources_o[i]),
      .glitch    (glitch_o[i])
    );
  end

endmodule

// File: tb/tb_plic_irq_cond.sv
// Scoreboard bench for plic_irq_cond: stimulus queues expected output values per cycle,
// a negedge monitor pops and compares them.
module tb_plic_irq_cond;

  localparam int NS = 30;
  localparam int FW = 4;
  localparam logic [NS-1:0] ALL = '1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NS-1:0] irq_raw_i, inv_i, filt_en_i, glitch_clr_i;
  logic [FW-1:0] filt_len_i;
  logic [NS-1:0] irq_sources_o, glitch_o;

  plic_irq_cond #(.N_SOURCE(NS), .SYNC_STAGES(2), .FILT_W(FW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_raw_i    (irq_raw_i),
    .inv_i        (inv_i),
    .filt_en_i    (filt_en_i),
    .filt_len_i   (filt_len_i),
    .glitch_clr_i (glitch_clr_i),
    .irq_sources_o(irq_sources_o),
    .glitch_o     (glitch_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    int            cyc;
    logic [NS-1:0] m_irq;
    logic [NS-1:0] e_irq;
    logic [NS-1:0] m_gl;
    logic [NS-1:0] e_gl;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Expectation on the outputs as they stand after clock edge number 'at'.
  function automatic void expect_at(int at, logic [NS-1:0] m_irq, logic [NS-1:0] e_irq,
                                    logic [NS-1:0] m_gl, logic [NS-1:0] e_gl, string nm);
    exp_t e;
    e.cyc = at; e.m_irq = m_irq; e.e_irq = e_irq & m_irq; e.m_gl = m_gl; e.e_gl = e_gl & m_gl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  function automatic logic [NS-1:0] bit_of(int i);
    logic [NS-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk_i) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        n_cmp++;
        if (exp_q[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: check for edge %0d missed at edge %0d", name_q[i], exp_q[i].cyc, cyc);
        end else if (((irq_sources_o & exp_q[i].m_irq) !== exp_q[i].e_irq) ||
                     ((glitch_o & exp_q[i].m_gl) !== exp_q[i].e_gl)) begin
          n_fail++;
          $display("FAIL %s @edge %0d: irq=%h want %h, glitch=%h want %h", name_q[i], cyc,
                   irq_sources_o & exp_q[i].m_irq, exp_q[i].e_irq,
                   glitch_o & exp_q[i].m_gl, exp_q[i].e_gl);
        end
        exp_q.delete(i);
        name_q.delete(i);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int b;
    rst_ni = 1'b0; irq_raw_i = ALL; inv_i = '0; filt_en_i = '0;
    filt_len_i = '0; glitch_clr_i = '0;

    // Reset: all zero while asserted, all ones exactly 3 edges after release.
    step(2);
    expect_at(cyc, ALL, '0, ALL, '0, "reset_outputs");
    step(1);
    rst_ni = 1'b1; b = cyc;
    expect_at(b + 2, ALL, '0, ALL, '0, "release_plus2");
    expect_at(b + 3, ALL, ALL, ALL, '0, "release_plus3");
    step(4);
    irq_raw_i = '0; b = cyc;
    expect_at(b + 3, ALL, '0, ALL, '0, "all_fall");
    step(5);

    // Source 0, filter length 4: a 3-cycle pulse is rejected and flagged.
    filt_en_i[0] = 1'b1; filt_len_i = 4'd4;
    step(2);
    irq_raw_i[0] = 1'b1; b = cyc;
    expect_at(b + 5, bit_of(0), '0, bit_of(0), '0, "p3_glitch_before");
    expect_at(b + 6, bit_of(0), '0, bit_of(0), bit_of(0), "p3_glitch_set");
    expect_at(b + 7, bit_of(0), '0, bit_of(0), bit_of(0), "p3_irq_stays_low");
    step(3);
    irq_raw_i[0] = 1'b0;
    step(6);

    // A 4-cycle pulse passes at edge 6 and falls back after the filtered trailing edge.
    irq_raw_i[0] = 1'b1; b = cyc;
    expect_at(b + 5, bit_of(0), '0, bit_of(0), bit_of(0), "p4_edge5");
    expect_at(b + 6, bit_of(0), bit_of(0), bit_of(0), bit_of(0), "p4_edge6");
    expect_at(b + 9, bit_of(0), bit_of(0), bit_of(0), bit_of(0), "p4_hold");
    expect_at(b + 10, bit_of(0), '0, bit_of(0), bit_of(0), "p4_fall");
    step(4);
    irq_raw_i[0] = 1'b0;
    step(8);

    // Clear alone drops the flag.
    glitch_clr_i[0] = 1'b1; b = cyc;
    expect_at(b + 1, '0, '0, bit_of(0), '0, "clr_alone");
    step(1);
    glitch_clr_i[0] = 1'b0;
    step(2);

    // New glitch detected at edge b+6 with a concurrent clear: set wins; clear at b+7 wins.
    irq_raw_i[0] = 1'b1; b = cyc;
    expect_at(b + 6, bit_of(0), '0, bit_of(0), bit_of(0), "set_beats_clr");
    expect_at(b + 7, '0, '0, bit_of(0), '0, "clr_after_set");
    step(3);
    irq_raw_i[0] = 1'b0;
    step(2);
    glitch_clr_i[0] = 1'b1;
    step(2);
    glitch_clr_i[0] = 1'b0;
    step(3);

    // Source 5: polarity flip with the line low, filter off, acts after one edge.
    inv_i[5] = 1'b1; b = cyc;
    expect_at(b, bit_of(5), '0, '0, '0, "inv_before");
    expect_at(b + 1, bit_of(5), bit_of(5), bit_of(5), '0, "inv_rise");
    step(2);
    inv_i[5] = 1'b0; b = cyc;
    expect_at(b + 1, bit_of(5), '0, bit_of(5), '0, "inv_fall");
    step(3);

    // Source 1: length 15 shrinks to 2 while cnt is 5 -> commit on the next edge.
    filt_en_i[1] = 1'b1; filt_len_i = 4'd15;
    step(1);
    irq_raw_i[1] = 1'b1; b = cyc;
    expect_at(b + 7, bit_of(1), '0, bit_of(1), '0, "shrink_before");
    expect_at(b + 8, bit_of(1), bit_of(1), bit_of(1), '0, "shrink_commit");
    expect_at(b + 9, bit_of(1), bit_of(1), bit_of(1), '0, "shrink_no_glitch");
    step(7);
    filt_len_i = 4'd2;
    step(4);

    // Length 0 with the filter on matches the filter off (sources 2 and 3).
    filt_len_i = 4'd0; filt_en_i[2] = 1'b1; filt_en_i[3] = 1'b0;
    step(1);
    irq_raw_i[2] = 1'b1; irq_raw_i[3] = 1'b1; b = cyc;
    expect_at(b + 2, 30'hC, 30'h0, 30'hC, 30'h0, "len0_edge2");
    expect_at(b + 3, 30'hC, 30'hC, 30'hC, 30'h0, "len0_edge3");
    step(5);

    // Source 4: reset asserted at cnt 2 of an 8-cycle window discards the count.
    filt_en_i[4] = 1'b1; filt_len_i = 4'd8;
    step(1);
    irq_raw_i[4] = 1'b1; b = cyc;
    expect_at(b + 4, bit_of(4), '0, bit_of(4), '0, "midcount_pre");
    step(4);
    rst_ni = 1'b0; irq_raw_i = '0; b = cyc;
    expect_at(b + 1, ALL, '0, ALL, '0, "midcount_reset");
    step(2);
    rst_ni = 1'b1; b = cyc;
    expect_at(b + 12, ALL, '0, ALL, '0, "after_release");
    step(1);

    for (int t = 0; t < 60 && exp_q.size() > 0; t++) step(1);
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: check never reached (edge %0d)", name_q[0], exp_q[0].cyc);
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
